mem_access_unit: RTL and testbench

Memory-access stage directly downstream of the instruction frame register. It consumes the frame's load/store controls, memory length, store data, destination register and the execute-stage result (used as the effective address). It runs a request/acknowledge transaction on the data-memory port with byte-lane steering and load sign/zero extension, and stalls the frame while a transaction is outstanding. Its writeback bundle feeds the register file.

---
 rtl/mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: request/acknowledge data-memory transaction with byte-lane steering and load extension.
// Define MEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES cycles without ack, reported via bus_fault.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      load_in,
  input  logic                      loadUnsigned_in,
  input  logic                      store_in,
  input  logic [1:0]                memLength_in,
  input  logic [`DATA_WIDTH-1:0]    address_in,
  input  logic [`DATA_WIDTH-1:0]    storeData_in,
  input  logic [`REGADDR_WIDTH-1:0] writeSelect_in,
  input  logic                      writeEnable_in,
  output logic                      stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [`DATA_WIDTH-1:0]    mem_addr,
  output logic [3:0]                mem_byteEn,
  output logic [`DATA_WIDTH-1:0]    mem_wdata,
  input  logic                      mem_ack,
  input  logic [`DATA_WIDTH-1:0]    mem_rdata,
  output logic                      wb_valid,
  output logic [`DATA_WIDTH-1:0]    wb_result,
  output logic [`REGADDR_WIDTH-1:0] wb_writeSelect,
  output logic                      wb_writeEnable,
  output logic                      misalign_fault,
  output logic                      bus_fault
);

  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned RW = `REGADDR_WIDTH;
  localparam int unsigned CW = 16;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES out of range 2..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state, state_d;

  logic          mem_op, aligned, timeout_hit;
  logic [1:0]    offset;
  logic [3:0]    ben_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] rdata_shift, load_data;

  // Latched transaction context, held across REQ
  logic [1:0]    off_q, off_d;
  logic [1:0]    len_q, len_d;
  logic          uns_q, uns_d;
  logic [RW-1:0] wsel_q, wsel_d;
  logic          wen_q, wen_d;

  logic          mem_req_d, mem_we_d;
  logic [DW-1:0] mem_addr_d, mem_wdata_d;
  logic [3:0]    mem_byteEn_d;
  logic          wb_valid_d, wb_writeEnable_d, misalign_fault_d;
  logic [DW-1:0] wb_result_d;
  logic [RW-1:0] wb_writeSelect_d;

  assign mem_op = load_in | store_in;
  assign offset = address_in[1:0];

  // Alignment, lane enables and store-data replication for the incoming op
  always_comb begin
    aligned = 1'b0;
    ben_c   = 4'b1111;
    wdata_c = storeData_in;
    case (memLength_in)
      2'd0: begin
        aligned = 1'b1;
        ben_c   = 4'(4'b0001 << offset);
        wdata_c = DW'({4{storeData_in[7:0]}});
      end
      2'd1: begin
        aligned = ~offset[0];
        ben_c   = 4'(4'b0011 << offset);
        wdata_c = DW'({2{storeData_in[15:0]}});
      end
      2'd2: begin
        aligned = (offset == 2'd0);
      end
      default: begin
        aligned = 1'b0;
      end
    endcase
  end

  // Load return: shift the addressed lane down, then truncate and extend
  assign rdata_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = rdata_shift;
    case (len_q)
      2'd0:    load_data = {{(DW-8){~uns_q & rdata_shift[7]}}, rdata_shift[7:0]};
      2'd1:    load_data = {{(DW-16){~uns_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [CW-1:0] timeout_cnt;
  logic          bus_fault_d;

  assign timeout_hit = (state == REQ) && !mem_ack &&
                       (timeout_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_cnt <= '0;
    end else if (state == REQ && !mem_ack) begin
      timeout_cnt <= timeout_cnt + CW'(1);
    end else begin
      timeout_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_fault   = 1'b0;
`endif

  assign stall = !reset &&
                 (((state == IDLE) && valid_in && mem_op && aligned) ||
                  ((state == REQ) && !mem_ack && !timeout_hit));

  // Next state and next values of all registered outputs
  always_comb begin
    state_d          = state;
    mem_req_d        = 1'b0;
    mem_we_d         = mem_we;
    mem_addr_d       = mem_addr;
    mem_byteEn_d     = mem_byteEn;
    mem_wdata_d      = mem_wdata;
    off_d            = off_q;
    len_d            = len_q;
    uns_d            = uns_q;
    wsel_d           = wsel_q;
    wen_d            = wen_q;
    wb_valid_d       = 1'b0;
    wb_result_d      = '0;
    wb_writeSelect_d = '0;
    wb_writeEnable_d = 1'b0;
    misalign_fault_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    bus_fault_d      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (!mem_op) begin
            wb_valid_d       = 1'b1;
            wb_result_d      = address_in;
            wb_writeSelect_d = writeSelect_in;
            wb_writeEnable_d = writeEnable_in;
          end else if (!aligned) begin
            wb_valid_d       = 1'b1;
            wb_writeSelect_d = writeSelect_in;
            misalign_fault_d = 1'b1;
          end else begin
            state_d      = REQ;
            mem_req_d    = 1'b1;
            mem_we_d     = store_in;
            mem_addr_d   = {address_in[DW-1:2], 2'b00};
            mem_byteEn_d = ben_c;
            mem_wdata_d  = wdata_c;
            off_d        = offset;
            len_d        = memLength_in;
            uns_d        = loadUnsigned_in;
            wsel_d       = writeSelect_in;
            wen_d        = writeEnable_in;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d          = IDLE;
          wb_valid_d       = 1'b1;
          wb_writeSelect_d = wsel_q;
          if (!mem_we) begin
            wb_result_d      = load_data;
            wb_writeEnable_d = wen_q;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d          = IDLE;
          wb_valid_d       = 1'b1;
          wb_writeSelect_d = wsel_q;
          bus_fault_d      = 1'b1;
        end
`endif
        else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_byteEn     <= '0;
      mem_wdata      <= '0;
      off_q          <= '0;
      len_q          <= '0;
      uns_q          <= 1'b0;
      wsel_q         <= '0;
      wen_q          <= 1'b0;
      wb_valid       <= 1'b0;
      wb_result      <= '0;
      wb_writeSelect <= '0;
      wb_writeEnable <= 1'b0;
      misalign_fault <= 1'b0;
    end else begin
      mem_req        <= mem_req_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_byteEn     <= mem_byteEn_d;
      mem_wdata      <= mem_wdata_d;
      off_q          <= off_d;
      len_q          <= len_d;
      uns_q          <= uns_d;
      wsel_q         <= wsel_d;
      wen_q          <= wen_d;
      wb_valid       <= wb_valid_d;
      wb_result      <= wb_result_d;
      wb_writeSelect <= wb_writeSelect_d;
      wb_writeEnable <= wb_writeEnable_d;
      misalign_fault <= misalign_fault_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_fault <= 1'b0;
    end else begin
      bus_fault <= bus_fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: writeback expectations queued at issue, compared when wb_valid fires.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined (bench sets TIMEOUT_CYCLES = 4).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

module tb_mem_access_unit;

  logic        clk, reset, valid_in, load_in, loadUnsigned_in, store_in;
  logic [1:0]  memLength_in;
  logic [31:0] address_in, storeData_in, mem_addr, mem_wdata, mem_rdata, wb_result;
  logic [4:0]  writeSelect_in, wb_writeSelect;
  logic        writeEnable_in, stall, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_byteEn;
  logic        wb_valid, wb_writeEnable, misalign_fault, bus_fault;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  wsel;
    logic        wen;
    logic        mis;
    logic        bus;
  } wb_exp_t;

  wb_exp_t sb[$];
  wb_exp_t exp_wb, got_wb;
  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .load_in(load_in),
    .loadUnsigned_in(loadUnsigned_in), .store_in(store_in), .memLength_in(memLength_in),
    .address_in(address_in), .storeData_in(storeData_in), .writeSelect_in(writeSelect_in),
    .writeEnable_in(writeEnable_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_byteEn(mem_byteEn), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_result(wb_result),
    .wb_writeSelect(wb_writeSelect), .wb_writeEnable(wb_writeEnable),
    .misalign_fault(misalign_fault), .bus_fault(bus_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    valid_in = 0; load_in = 0; loadUnsigned_in = 0; store_in = 0; memLength_in = 0;
    address_in = 0; storeData_in = 0; writeSelect_in = 0; writeEnable_in = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    drive_idle();
    step();
    step();
    @(negedge clk);
    checks++;
    if ({stall, mem_req, mem_we, mem_byteEn, wb_valid, wb_writeEnable, misalign_fault, bus_fault} !== '0)
      begin errors++; $display("FAIL reset_ctrl: got %b required 0",
        {stall, mem_req, mem_we, mem_byteEn, wb_valid, wb_writeEnable, misalign_fault, bus_fault}); end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      begin errors++; $display("FAIL reset_mem: addr %h wdata %h required 0", mem_addr, mem_wdata); end
    checks++;
    if (wb_result !== 32'h0 || wb_writeSelect !== 5'h0)
      begin errors++; $display("FAIL reset_wb: result %h sel %h required 0", wb_result, wb_writeSelect); end
    step();
    reset = 0;
    step();
  endtask

  task automatic test_passthrough;
    valid_in = 1; address_in = 32'h1234_5678; writeSelect_in = 5; writeEnable_in = 1;
    sb.push_back('{32'h1234_5678, 5'd5, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b required 0", stall); end
    step();
    drive_idle();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL pass_valid: wb_valid %b queued %0d required 1", wb_valid, sb.size());
    end else begin
      exp_wb = sb.pop_front();
      got_wb = {wb_result, wb_writeSelect, wb_writeEnable, misalign_fault, bus_fault};
      checks++;
      if (got_wb !== exp_wb) begin errors++; $display("FAIL pass_wb: got %h required %h", got_wb, exp_wb); end
    end
    step();
  endtask

  // Issue one memory op, ack on the k-th REQ cycle, check bus side, stall length and writeback
  task automatic run_mem_op(input string name, input logic ld, input logic st, input logic uns,
                            input logic [1:0] len, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] wsel, input logic [31:0] rdata, input int k,
                            input logic [31:0] e_addr, input logic [3:0] e_ben,
                            input logic [31:0] e_wdata, input logic [31:0] e_result);
    int stall_cnt;
    stall_cnt = 0;
    valid_in = 1; load_in = ld; store_in = st; loadUnsigned_in = uns; memLength_in = len;
    address_in = addr; storeData_in = sdata; writeSelect_in = wsel; writeEnable_in = 1;
    sb.push_back('{e_result, wsel, ld, 1'b0, 1'b0});
    @(negedge clk);
    if (stall) stall_cnt++;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL %s_early_req: got %b required 0", name, mem_req); end
    step();
    for (int j = 1; j <= k; j++) begin
      mem_ack = (j == k);
      mem_rdata = (j == k) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (stall) stall_cnt++;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_byteEn, mem_wdata} !== {1'b1, st, e_addr, e_ben, e_wdata}) begin
        errors++;
        $display("FAIL %s_bus c%0d: req %b we %b addr %h ben %b wdata %h required 1 %b %h %b %h",
                 name, j, mem_req, mem_we, mem_addr, mem_byteEn, mem_wdata, st, e_addr, e_ben, e_wdata);
      end
      step();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (stall_cnt != k) begin errors++; $display("FAIL %s_stall_len: got %0d required %0d", name, stall_cnt, k); end
    checks++;
    if (wb_valid !== 1'b1 || mem_req !== 1'b0 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_wb_valid: wb_valid %b mem_req %b required 1 0", name, wb_valid, mem_req);
    end else begin
      exp_wb = sb.pop_front();
      got_wb = {wb_result, wb_writeSelect, wb_writeEnable, misalign_fault, bus_fault};
      checks++;
      if (got_wb !== exp_wb) begin errors++; $display("FAIL %s_wb: got %h required %h", name, got_wb, exp_wb); end
    end
    step();
  endtask

  task automatic test_loads;
    run_mem_op("ld_byte_s", 1, 0, 0, 2'd0, 32'h1003, 32'h0, 5'd7, 32'h80FF_0000, 3,
               32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_mem_op("ld_byte_u", 1, 0, 1, 2'd0, 32'h1003, 32'h0, 5'd7, 32'h80FF_0000, 1,
               32'h1000, 4'b1000, 32'h0, 32'h0000_0080);
    run_mem_op("ld_half_s", 1, 0, 0, 2'd1, 32'h1002, 32'h0, 5'd9, 32'h8001_1234, 2,
               32'h1000, 4'b1100, 32'h0, 32'hFFFF_8001);
    run_mem_op("ld_word", 1, 0, 0, 2'd2, 32'h4000, 32'h0, 5'd12, 32'hCAFE_F00D, 1,
               32'h4000, 4'b1111, 32'h0, 32'hCAFE_F00D);
    run_mem_op("ld_ack_c4", 1, 0, 1, 2'd1, 32'h4000, 32'h0, 5'd4, 32'h0000_9ABC, 4,
               32'h4000, 4'b0011, 32'h0, 32'h0000_9ABC);
  endtask

  task automatic test_stores;
    run_mem_op("st_half", 0, 1, 0, 2'd1, 32'h2002, 32'hAAAA_BEEF, 5'd3, 32'h0, 2,
               32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_mem_op("st_byte", 0, 1, 0, 2'd0, 32'h2001, 32'h1234_565A, 5'd6, 32'h0, 1,
               32'h2000, 4'b0010, 32'h5A5A_5A5A, 32'h0);
  endtask

  task automatic test_misalign;
    logic [31:0] addrs [3];
    logic [1:0]  lens  [3];
    addrs = '{32'h3001, 32'h3000, 32'h3003};
    lens  = '{2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      valid_in = 1; load_in = 1; memLength_in = lens[i]; address_in = addrs[i];
      writeSelect_in = 5'd10; writeEnable_in = 1;
      sb.push_back('{32'h0, 5'd10, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL mis%0d_stall: got %b required 0", i, stall); end
      step();
      drive_idle();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL mis%0d_valid: req %b wb_valid %b required 0 1", i, mem_req, wb_valid);
      end else begin
        exp_wb = sb.pop_front();
        got_wb = {wb_result, wb_writeSelect, wb_writeEnable, misalign_fault, bus_fault};
        checks++;
        if (got_wb !== exp_wb) begin errors++; $display("FAIL mis%0d_wb: got %h required %h", i, got_wb, exp_wb); end
      end
      step();
      @(negedge clk);
      checks++;
      if (misalign_fault !== 1'b0 || wb_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL mis%0d_pulse: fault %b wb_valid %b req %b required 0", i, misalign_fault, wb_valid, mem_req);
      end
      step();
    end
  endtask

  task automatic test_reset_in_req;
    valid_in = 1; load_in = 1; memLength_in = 2'd2; address_in = 32'h5000;
    writeSelect_in = 5'd11; writeEnable_in = 1;
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_req_c1: got %b required 1", mem_req); end
    step();
    reset = 1;
    valid_in = 0;
    step();
    reset = 0;
    mem_ack = 1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    checks++;
    if ({mem_req, wb_valid, stall} !== 3'b000) begin
      errors++; $display("FAIL rst_after: req/wb_valid/stall %b required 000", {mem_req, wb_valid, stall});
    end
    step();
    mem_ack = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, wb_valid, wb_writeEnable} !== 3'b000) begin
      errors++; $display("FAIL rst_late_ack: req/wb_valid/wen %b required 000", {mem_req, wb_valid, wb_writeEnable});
    end
    drive_idle();
    step();
  endtask

  task automatic test_back_to_back;
    valid_in = 1; load_in = 1; memLength_in = 2'd2; address_in = 32'h4000;
    writeSelect_in = 5'd8; writeEnable_in = 1;
    sb.push_back('{32'h1122_3344, 5'd8, 1'b1, 1'b0, 1'b0});
    step();
    mem_ack = 1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_a_req: req %b stall %b required 1 0", mem_req, stall);
    end
    step();
    mem_ack = 0; mem_rdata = 0;
    load_in = 0; store_in = 1; memLength_in = 2'd0; address_in = 32'h4005;
    storeData_in = 32'h0000_00A5; writeSelect_in = 5'd2;
    sb.push_back('{32'h0, 5'd2, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL b2b_accept: stall %b wb_valid %b required 1 1", stall, wb_valid);
    end else begin
      exp_wb = sb.pop_front();
      got_wb = {wb_result, wb_writeSelect, wb_writeEnable, misalign_fault, bus_fault};
      checks++;
      if (got_wb !== exp_wb) begin errors++; $display("FAIL b2b_a_wb: got %h required %h", got_wb, exp_wb); end
    end
    step();
    mem_ack = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_byteEn, mem_wdata} !== {1'b1, 1'b1, 32'h4004, 4'b0010, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL b2b_b_bus: req %b we %b addr %h ben %b wdata %h", mem_req, mem_we, mem_addr, mem_byteEn, mem_wdata);
    end
    step();
    drive_idle();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL b2b_b_valid: got %b required 1", wb_valid);
    end else begin
      exp_wb = sb.pop_front();
      got_wb = {wb_result, wb_writeSelect, wb_writeEnable, misalign_fault, bus_fault};
      checks++;
      if (got_wb !== exp_wb) begin errors++; $display("FAIL b2b_b_wb: got %h required %h", got_wb, exp_wb); end
    end
    step();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    valid_in = 1; load_in = 1; memLength_in = 2'd2; address_in = 32'h6000;
    writeSelect_in = 5'd9; writeEnable_in = 1;
    sb.push_back('{32'h0, 5'd9, 1'b0, 1'b0, 1'b1});
    step();
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || stall !== (j < 4)) begin
        errors++; $display("FAIL tmo_c%0d: req %b stall %b required 1 %b", j, mem_req, stall, (j < 4));
      end
      step();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL tmo_abort: req %b wb_valid %b required 0 1", mem_req, wb_valid);
    end else begin
      exp_wb = sb.pop_front();
      got_wb = {wb_result, wb_writeSelect, wb_writeEnable, misalign_fault, bus_fault};
      checks++;
      if (got_wb !== exp_wb) begin errors++; $display("FAIL tmo_wb: got %h required %h", got_wb, exp_wb); end
    end
    step();
    @(negedge clk);
    checks++;
    if (bus_fault !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse: bus_fault %b wb_valid %b required 0 0", bus_fault, wb_valid);
    end
    step();
  endtask
`endif

  initial begin
    drive_idle();
    reset = 1;
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_misalign();
    test_reset_in_req();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expectations left, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
